// File: rtl/sort4_cmp_ctrl.sv
// Burst bubble-sort engine: captures N samples, sorts them ascending using an
// external combinational comparator, then streams them out with valid/ready.
module sort4_cmp_ctrl #(
    parameter int N = 4,
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         in_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    input  logic         out_ready,
    output logic [W-1:0] cmp_a,
    output logic [W-1:0] cmp_b,
    input  logic         cmp_g,
    input  logic         cmp_l,
    input  logic         cmp_e,
    output logic         busy,
    output logic         cmp_err,
    output logic [1:0]   state_dbg
);
    // Handshakes: a transfer happens on a rising edge where valid && ready are
    // both high; valid never depends on ready, and data is held while stalled.

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST_ENTRY = IW'(N - 1);
    localparam logic [IW-1:0] LAST_CMP   = IW'(N - 2);

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        SORT  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [W-1:0]  mem [N];
    logic [IW-1:0] wr_idx;
    logic [IW-1:0] rd_idx;
    logic [IW-1:0] idx;
    logic [IW-1:0] pass;
    logic [IW-1:0] idx_p1;
    logic          cmp_ok;
    logic          do_swap;

    assign idx_p1    = idx + IW'(1);
    assign state_dbg = state;

    // A result that is not exactly one-hot is flagged and never causes a swap.
    assign cmp_ok  = $onehot({cmp_g, cmp_l, cmp_e});
    assign do_swap = (state == SORT) && cmp_ok && cmp_g;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        cmp_a     = '0;
        cmp_b     = '0;
        busy      = 1'b0;
        case (state)
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid && (wr_idx == LAST_ENTRY)) begin
                    state_nxt = SORT;
                end
            end
            SORT: begin
                busy  = 1'b1;
                cmp_a = mem[idx];
                cmp_b = mem[idx_p1];
                if ((idx == LAST_CMP) && (pass == LAST_CMP)) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_data  = mem[rd_idx];
                if (out_ready && (rd_idx == LAST_ENTRY)) begin
                    state_nxt = LOAD;
                end
            end
            default: begin
                state_nxt = LOAD;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                mem[i] <= '0;
            end
            wr_idx  <= '0;
            rd_idx  <= '0;
            idx     <= '0;
            pass    <= '0;
            cmp_err <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    if (in_valid) begin
                        mem[wr_idx] <= in_data;
                        wr_idx      <= (wr_idx == LAST_ENTRY) ? '0 : wr_idx + IW'(1);
                    end
                end
                SORT: begin
                    if (!cmp_ok) begin
                        cmp_err <= 1'b1;
                    end
                    if (do_swap) begin
                        mem[idx]    <= cmp_b;
                        mem[idx_p1] <= cmp_a;
                    end
                    // Fixed schedule: (N-1) passes of (N-1) compares, no early exit.
                    if (idx == LAST_CMP) begin
                        idx  <= '0;
                        pass <= (pass == LAST_CMP) ? '0 : pass + IW'(1);
                    end else begin
                        idx <= idx_p1;
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        rd_idx <= (rd_idx == LAST_ENTRY) ? '0 : rd_idx + IW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sort4_cmp_ctrl.sv
// Bench for sort4_cmp_ctrl: plays the external comparator, drives bursts,
// and checks the sorted stream, latency and handshakes against a reference.
module tb_sort4_cmp_ctrl;
    localparam int N  = 4;
    localparam int W  = 5;
    localparam int NC = (N - 1) * (N - 1);

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         out_ready = 1'b0;
    logic         fault_en = 1'b0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic [W-1:0] cmp_a;
    logic [W-1:0] cmp_b;
    logic         cmp_g;
    logic         cmp_l;
    logic         cmp_e;
    logic         busy;
    logic         cmp_err;
    logic [1:0]   state_dbg;

    int errors = 0;
    int checks = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] burst [N];
    int swaps_seen;
    int swaps_exp;
    logic exp_err = 1'b0;

    // Comparator model; fault_en forces an illegal G+L result.
    assign cmp_g = fault_en ? 1'b1 : (cmp_a > cmp_b);
    assign cmp_l = fault_en ? 1'b1 : (cmp_a < cmp_b);
    assign cmp_e = fault_en ? 1'b0 : (cmp_a == cmp_b);

    sort4_cmp_ctrl #(.N(N), .W(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .cmp_a(cmp_a), .cmp_b(cmp_b),
        .cmp_g(cmp_g), .cmp_l(cmp_l), .cmp_e(cmp_e),
        .busy(busy), .cmp_err(cmp_err), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: the fixed-schedule bubble sort on plain ints; skip_k marks a
    // compare slot whose result is illegal and therefore swaps nothing.
    task automatic model(input int skip_k);
        int m [N];
        int k;
        int t;
        k = 0;
        swaps_exp = 0;
        exp_q.delete();
        for (int i = 0; i < N; i++) m[i] = int'(burst[i]);
        for (int p = 0; p < N - 1; p++) begin
            for (int i = 0; i < N - 1; i++) begin
                if (k != skip_k && m[i] > m[i+1]) begin
                    t = m[i]; m[i] = m[i+1]; m[i+1] = t;
                    swaps_exp++;
                end
                k++;
            end
        end
        for (int i = 0; i < N; i++) exp_q.push_back(W'(m[i]));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, in_ready, 1);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_data"}, out_data, 0);
        check({tag, "_cmp_a"}, cmp_a, 0);
        check({tag, "_cmp_b"}, cmp_b, 0);
        check({tag, "_cmp_err"}, cmp_err, 0);
        check({tag, "_state"}, state_dbg, 0);
    endtask

    // Leaves the bench at the first negedge of SORT.
    task automatic load_burst(input bit gaps);
        int n;
        int guard;
        n = 0;
        guard = 0;
        while (n < N && guard < 200) begin
            @(negedge clk);
            guard++;
            check("in_ready_load", in_ready, 1);
            if (gaps && $urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                in_data  = W'($urandom);
            end else begin
                in_valid = 1'b1;
                in_data  = burst[n];
                n++;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Walks the SORT window. The accept edge counts as edge 1, so out_valid
    // is low through NC cycles and high on the (NC+1)th edge.
    task automatic sort_phase(input int fault_k, input int rst_k, input bit junk);
        logic [W-1:0] pa;
        logic [W-1:0] pb;
        bit pswap;
        pa = '0;
        pb = '0;
        pswap = 1'b0;
        swaps_seen = 0;
        for (int k = 0; k < NC; k++) begin
            if (k > 0) @(negedge clk);
            if (k == rst_k) begin
                rst_n = 1'b0;
                fault_en = 1'b0;
                in_valid = 1'b0;
                #1;
                check_reset_outputs("mid_sort_rst");
                exp_err = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            check("sort_busy", busy, 1);
            check("sort_out_valid", out_valid, 0);
            check("sort_in_ready", in_ready, 0);
            check("sort_cmp_err", cmp_err, (fault_k >= 0 && k > fault_k) ? 1'b1 : exp_err);
            if (junk) begin
                in_valid = 1'($urandom_range(0, 1));
                in_data  = W'($urandom);
            end
            fault_en = (k == fault_k);
            #1;
            // Within a pass the next compare's A operand is whichever value
            // the previous compare left in the upper slot.
            if (k % (N - 1) != 0) check("swap_follow", cmp_a, pswap ? pa : pb);
            pa = cmp_a;
            pb = cmp_b;
            pswap = cmp_g && !cmp_l && !cmp_e;
            if (pswap) swaps_seen++;
        end
        @(negedge clk);
        fault_en = 1'b0;
        in_valid = 1'b0;
        if (fault_k >= 0) exp_err = 1'b1;
        check("out_valid_rise", out_valid, 1);
        check("swap_count", swaps_seen, swaps_exp);
    endtask

    // mode 0: out_ready held high, 1: fixed 1,0,0,1,1,0,1 pattern, 2: random.
    task automatic drain(input int mode, input bit junk);
        int pat [7];
        int j;
        int cyc;
        logic r;
        pat = '{1, 0, 0, 1, 1, 0, 1};
        j = 0;
        cyc = 0;
        while (j < N && cyc < 100) begin
            if (cyc > 0) @(negedge clk);
            case (mode)
                0: r = 1'b1;
                1: r = (pat[cyc % 7] != 0);
                default: r = 1'($urandom_range(0, 1));
            endcase
            out_ready = r;
            if (junk) begin
                in_valid = 1'($urandom_range(0, 1));
                in_data  = W'($urandom);
            end
            check("drain_out_valid", out_valid, 1);
            check("drain_in_ready", in_ready, 0);
            check("drain_out_data", out_data, exp_q[j]);
            if (r) j++;
            cyc++;
        end
        check("drain_transfers", j, N);
        if (mode == 0) check("drain_cycles", cyc, N);
        if (mode == 1) check("drain_cycles_bp", cyc, 7);
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("post_in_ready", in_ready, 1);
        check("post_out_valid", out_valid, 0);
        check("post_busy", busy, 0);
        check("post_cmp_err", cmp_err, exp_err);
    endtask

    task automatic set_burst(input int a, input int b, input int c, input int d);
        burst[0] = W'(a); burst[1] = W'(b); burst[2] = W'(c); burst[3] = W'(d);
    endtask

    initial begin
        // Reset
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        check_reset_outputs("por");
        @(negedge clk);
        rst_n = 1'b1;

        // Basic sort
        set_burst(17, 3, 31, 0);
        model(-1);
        load_burst(1'b0);
        sort_phase(-1, -1, 1'b0);
        drain(0, 1'b0);

        // Duplicates: equal operands must never swap
        set_burst(5, 5, 2, 5);
        model(-1);
        load_burst(1'b0);
        sort_phase(-1, -1, 1'b0);
        drain(0, 1'b0);

        // Already sorted, then reverse sorted
        set_burst(1, 2, 3, 4);
        model(-1);
        load_burst(1'b0);
        sort_phase(-1, -1, 1'b0);
        drain(0, 1'b0);
        set_burst(31, 20, 10, 0);
        model(-1);
        load_burst(1'b0);
        sort_phase(-1, -1, 1'b0);
        drain(0, 1'b0);

        // Backpressure with stray in_valid pulses during SORT and DRAIN
        set_burst(12, 30, 7, 7);
        model(-1);
        load_burst(1'b0);
        sort_phase(-1, -1, 1'b1);
        drain(1, 1'b1);

        // Reset at SORT cycle 4, then a fresh burst
        set_burst(25, 1, 14, 3);
        model(-1);
        load_burst(1'b0);
        sort_phase(-1, 4, 1'b0);
        set_burst(9, 8, 7, 6);
        model(-1);
        load_burst(1'b0);
        sort_phase(-1, -1, 1'b0);
        drain(0, 1'b0);

        // Illegal comparator result on compare slot 1
        set_burst(31, 20, 10, 0);
        model(1);
        load_burst(1'b0);
        sort_phase(1, -1, 1'b0);
        drain(0, 1'b0);

        // Random bursts; cmp_err must stay set throughout
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < N; i++) burst[i] = W'($urandom_range(0, 31));
            model(-1);
            load_burst(1'b1);
            sort_phase(-1, -1, 1'b1);
            drain(2, 1'b1);
        end

        // Only reset clears cmp_err
        rst_n = 1'b0;
        #1;
        check_reset_outputs("final_rst");
        @(negedge clk);
        rst_n = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sort4_cmp_ctrl.md
# sort4_cmp_ctrl

Sequential bubble-sort engine that collects a burst of N unsigned 5-bit samples, sorts them ascending, and streams them out. It does not compare values itself. It drives the operand pair of the team's external combinational 5-bit magnitude comparator and consumes that comparator's G/L/E result. It therefore sits on both sides of the comparator: it feeds it and it consumes its output.

## Interface
Parameters:
- N, 4, number of entries per burst (2..8)
- W, 5, sample width; must match the comparator width

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input sample valid
- in_data  in  W  input sample (unsigned)
- in_ready  out  1  block accepts a sample this cycle
- out_valid  out  1  sorted sample valid
- out_data  out  W  sorted sample, ascending order
- out_ready  in  1  downstream accepts a sample
- cmp_a  out  W  comparator operand A = mem[idx]
- cmp_b  out  W  comparator operand B = mem[idx+1]
- cmp_g  in  1  comparator A>B
- cmp_l  in  1  comparator A<B
- cmp_e  in  1  comparator A==B
- busy  out  1  high in SORT or DRAIN
- cmp_err  out  1  sticky: comparator result was not one-hot during SORT

## Operation
- Storage: N×W register array mem, index counters of width clog2(N).
- FSM states: LOAD, SORT, DRAIN. Reset state is LOAD.
- LOAD:
  - in_ready=1.
  - Each cycle with in_valid && in_ready writes mem[wr_idx]=in_data and increments wr_idx.
  - On the Nth accepted sample, wr_idx wraps to 0 and the FSM moves to SORT.
- SORT: fixed bubble sort of (N-1) passes × (N-1) compares.
  - Each cycle: cmp_a=mem[idx], cmp_b=mem[idx+1].
  - If cmp_g=1, swap mem[idx] and mem[idx+1] at the clock edge. If cmp_l or cmp_e, no change. Equal values are never swapped, so the sort is stable.
  - idx runs 0..N-2, then wraps to 0 and increments pass.
  - After the last compare (pass=N-2, idx=N-2), go to DRAIN.
  - No early exit.
- Comparator check: if {cmp_g,cmp_l,cmp_e} is not exactly one-hot in any SORT cycle, set cmp_err. Also treat that cycle as no-swap. cmp_err clears only on reset.
- Outside SORT: cmp_a=cmp_b=0. The comparator inputs are ignored.
- DRAIN:
  - out_valid=1 and out_data=mem[rd_idx].
  - On out_valid && out_ready, rd_idx increments.
  - After the Nth transfer, rd_idx wraps to 0 and the FSM returns to LOAD.
- Both in_ready=0 and in_valid are ignored in SORT and DRAIN. Samples presented then are not captured.
- Arithmetic: unsigned only. No width growth. Values 0..2^W-1 pass through unchanged.

## Timing
- Reset (rst_n=0, asynchronous): state=LOAD, all indices=0, mem=0, out_valid=0, out_data=0, in_ready=1 (combinational from state), busy=0, cmp_err=0, cmp_a=cmp_b=0.
- The comparator is combinational. The cmp_* result is sampled in the same cycle its operands are driven.
- Latency, measured from the edge that accepts the Nth input:
  - SORT occupies exactly (N-1)² cycles (9 for N=4).
  - out_valid rises on the following edge, i.e. (N-1)²+1 edges after the last accept.
- DRAIN with out_ready held high takes N cycles. in_ready returns high the cycle after the last output transfer.
- Minimum burst period for N=4 with no stalls: 4+9+4=17 cycles.
- Backpressure: while out_ready=0, out_valid stays high and out_data stays stable.
- Reset mid-operation (any state): the partial burst is discarded and the block restarts in LOAD with the reset values listed above.
- A stalled in_valid=0 in LOAD holds wr_idx. Partial bursts wait indefinitely.

## Test plan
- Basic sort, N=4: load 17,3,31,0 → after 9 SORT cycles, out stream 0,3,17,31; out_valid rises 10 edges after the 4th accept.
- Duplicates and stability: load 5,5,2,5 → out 2,5,5,5; no swap occurs in any cycle where cmp_e=1. Check with a swap-count monitor.
- Already sorted / reverse sorted:
  - Load 1,2,3,4 → zero swaps.
  - Load 31,20,10,0 → 6 swaps.
  - Both take exactly 9 SORT cycles.
- Backpressure and handshake:
  - Toggle out_ready as 1,0,0,1,1,0,1 → out_data stable while stalled, exactly 4 transfers.
  - in_valid pulses during SORT/DRAIN are not captured.
  - in_ready returns 1 the cycle after the last transfer.
- Reset mid-SORT: assert rst_n=0 at SORT cycle 4 → all outputs show their reset values immediately. A new burst 9,8,7,6 → out 6,7,8,9.
- Comparator fault: force cmp_g=cmp_l=1 in one SORT cycle → cmp_err=1 and stays set, that pair is not swapped, and the rest of the burst completes normally.
